// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, drives mux selects and strobes, stalls on mem_ready, counts retirements.
module multicycle_control #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [1:0]       alu_op,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_src,
   output logic             iord,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             pc_en,
   output logic             illegal_op,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_retired
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;
   localparam logic [3:0] S_JREX    = 4'd12;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] FN_JR   = 6'b001000;

   logic [3:0] next_state;
   logic       illegal_dec;
   logic       retire;
   logic       pc_write;
   logic       branch;
   logic       mem_read_raw;
   logic       mem_write_raw;
   logic       ir_write_raw;
   logic       reg_write_raw;

   always_comb begin
      next_state  = S_FETCH;
      illegal_dec = 1'b0;
      case (state)
         S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_R:         next_state = (funct == FN_JR) ? S_JREX : S_RTYPEEX;
               OP_BEQ:       next_state = S_BEQEX;
               OP_ADDI:      next_state = S_ADDIEX;
               OP_J:         next_state = S_JEX;
               default: begin
                  next_state  = S_FETCH;
                  illegal_dec = 1'b1;
               end
            endcase
         end
         S_MEMADR:  next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: next_state = S_ALUWB;
         S_ADDIEX:  next_state = S_ADDIWB;
         default:   next_state = S_FETCH;
      endcase
   end

   always_comb begin
      case (state)
         S_MEMWB, S_ALUWB, S_ADDIWB,
         S_BEQEX, S_JEX, S_JREX: retire = 1'b1;
         S_MEMWR:                retire = mem_ready;
         default:                retire = 1'b0;
      endcase
   end

   always_comb begin
      alu_op        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_src        = 2'b00;
      iord          = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      mem_read_raw  = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      pc_write      = 1'b0;
      branch        = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read_raw = 1'b1;
            alu_src_b    = 2'b01;
            ir_write_raw = mem_ready;
            pc_write     = mem_ready;
         end
         S_DECODE: alu_src_b = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            iord         = 1'b1;
            mem_read_raw = 1'b1;
         end
         S_MEMWB: begin
            mem_to_reg    = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_MEMWR: begin
            iord          = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_RTYPEEX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_dst       = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_ADDIWB: reg_write_raw = 1'b1;
         S_BEQEX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch    = 1'b1;
         end
         S_JEX: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         S_JREX: begin
            pc_src   = 2'b11;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are suppressed combinationally while reset is high, even before the state register clears.
   assign mem_read   = mem_read_raw  & ~reset;
   assign mem_write  = mem_write_raw & ~reset;
   assign ir_write   = ir_write_raw  & ~reset;
   assign reg_write  = reg_write_raw & ~reset;
   assign pc_en      = (pc_write | (branch & zero)) & ~reset;
   assign illegal_op = illegal_dec & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_FETCH;
         instr_retired <= '0;
      end else begin
         state <= next_state;
         if (retire) instr_retired <= instr_retired + 1'b1;
      end
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU control decoder and drives its 2-bit alu_op (00 add, 01 sub, 10 funct-decoded).
- Sequences fetch/decode/execute/memory/writeback.
- Drives all datapath mux selects and write strobes.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
alu_op  output  2  to ALU control decoder
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=reg A (jr)
iord  output  1  memory address select: 0=PC, 1=ALUOut
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=memory data reg
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load instruction register
reg_write  output  1  register file write enable
pc_en  output  1  PC load = pc_write | (branch & zero)
illegal_op  output  1  one-cycle pulse on unsupported opcode
state  output  4  current state (debug)
instr_retired  output  CNT_W  retired-instruction count

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010. jr = R-type with funct 001000.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, JREX 12. Codes 13-15 are unreachable; they go to FETCH next cycle with all strobes 0.
- Outputs are Moore decodes of state, except the mem_ready gating noted below. Any output not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_write=mem_ready. Stay until mem_ready=1, then go to DECODE.
- DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state:
  - lw/sw: MEMADR
  - R (funct≠001000): RTYPEEX
  - jr: JREX
  - beq: BEQEX
  - addi: ADDIEX
  - j: JEX
  - other: FETCH, with illegal_op=1 in this cycle only.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD if opcode is lw, else MEMWR.
- MEMRD: iord=1, mem_read=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: mem_to_reg=1, reg_dst=0, reg_write=1. Go to FETCH.
- MEMWR: iord=1, mem_write=1, held every cycle until mem_ready, then go to FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_dst=1, reg_write=1. Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
- ADDIWB: reg_dst=0, reg_write=1. Go to FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Go to FETCH.
- JEX: pc_src=10, pc_write=1. Go to FETCH.
- JREX: pc_src=11, pc_write=1. Go to FETCH.
- pc_en = pc_write | (branch & zero), combinational within the cycle.
- instr_retired increments by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, ADDIWB, BEQEX, JEX or JREX.
  - Illegal opcodes are not counted.
  - The counter wraps modulo 2^CNT_W.
- opcode/funct are sampled only in DECODE and MEMADR; the IR is stable after FETCH.
- Reset (sync, any state including mid-stall): next state FETCH, instr_retired=0.
  - While reset=1, pc_en, ir_write, reg_write, mem_write, mem_read and illegal_op are forced to 0.
- Post-reset values: state=0, alu_op=00, alu_src_b=01, all other selects and strobes 0 until the first cycle with reset low.
  - The FETCH decode then applies, e.g. mem_read=1.

Test Plan:
- Reset held 3 cycles from random state, then released with mem_ready=1 → state=0, instr_retired=0, no write strobe during reset; ir_write=pc_en=1 on first cycle after release.
- lw, mem_ready=1 always → states 0,1,2,3,4,0; alu_op 00 throughout; reg_write only in MEMWB; instr_retired +1 after 5 cycles.
- add (funct 100000) → states 0,1,6,7,0; alu_op=10 in RTYPEEX; reg_dst=1 with reg_write in ALUWB.
- beq with zero=1, then with zero=0 → BEQEX alu_op=01, pc_src=01; pc_en=1 and 0 respectively; both retire.
- sw with mem_ready low 4 cycles in MEMWR → mem_write high 5 cycles, state stays 5, counter increments only on mem_ready edge.
- Opcode 111111 → illegal_op one-cycle pulse in DECODE, return to FETCH, instr_retired unchanged.
- jr (R, funct 001000) → JREX, pc_src=11, pc_en=1.
